// File: rtl/ifid_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifid_hazard_stage
// Brief    : IF/ID pipeline register with load-use, branch-squash and
//            fixed-length mul/div stall control for the 16-bit core.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_hazard_stage #(
  parameter int          MULDIV_CYCLES = 4,
  parameter logic [15:0] NOP_WORD      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  input  logic        branch_taken,
  input  logic        idex_memread,
  input  logic [3:0]  idex_rd,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [3:0]  funct_out,
  output logic        pc_write,
  output logic        idex_flush,
  output logic        stall
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MD_STALL = 1'b1
  } state_t;

  localparam logic [3:0] c_md_init = 4'(MULDIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_md_cnt;
  logic [3:0]  w_md_cnt_nxt;
  logic [15:0] w_instr_nxt;
  logic [15:0] w_pc_nxt;
  logic        w_valid_nxt;
  logic        w_load_use;
  logic        w_is_md;

  assign rs_addr   = instr_out[11:8];
  assign rt_addr   = instr_out[7:4];
  assign funct_out = instr_out[3:0];

  // Register 0 is compared like any other register.
  assign w_load_use = valid_out & idex_memread &
                      ((idex_rd == rs_addr) | (idex_rd == rt_addr));
  assign w_is_md    = valid_out & (instr_out[15:12] == 4'h0) &
                      ((funct_out == 4'h4) | (funct_out == 4'h5));

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_instr_nxt  = instr_out;
    w_pc_nxt     = pc_out;
    w_valid_nxt  = valid_out;
    pc_write     = 1'b1;
    idex_flush   = 1'b0;
    stall        = 1'b0;

    if (branch_taken) begin
      w_instr_nxt  = NOP_WORD;
      w_pc_nxt     = pc_in;
      w_valid_nxt  = 1'b0;
      idex_flush   = 1'b1;
      w_state_nxt  = ST_RUN;
      w_md_cnt_nxt = 4'd0;
    end else if (r_state == ST_MD_STALL) begin
      pc_write   = 1'b0;
      idex_flush = 1'b1;
      stall      = 1'b1;
      if (r_md_cnt == 4'd1) begin
        w_state_nxt  = ST_RUN;
        w_md_cnt_nxt = 4'd0;
      end else begin
        w_md_cnt_nxt = r_md_cnt - 4'd1;
      end
    end else if (w_load_use) begin
      pc_write   = 1'b0;
      idex_flush = 1'b1;
      stall      = 1'b1;
    end else begin
      // The mul/div itself proceeds into ID/EX; the bubbles follow it.
      w_instr_nxt = instr_in;
      w_pc_nxt    = pc_in;
      w_valid_nxt = 1'b1;
      if (w_is_md) begin
        w_state_nxt  = ST_MD_STALL;
        w_md_cnt_nxt = c_md_init;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_md_cnt  <= 4'd0;
      instr_out <= NOP_WORD;
      pc_out    <= 16'h0000;
      valid_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_md_cnt  <= w_md_cnt_nxt;
      instr_out <= w_instr_nxt;
      pc_out    <= w_pc_nxt;
      valid_out <= w_valid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/ifid_hazard_stage.md
# ifid_hazard_stage

IF/ID pipeline register with integrated hazard control for the 16-bit pipelined core. Captures the fetched instruction and PC, presents decoded register addresses to the register file and the ID/EX buffer, and produces the PC write-enable and the ID/EX flush strobe. Handles three cases:
- load-use stalls;
- taken-branch squashes;
- fixed-length multi-cycle stalls for multiply/divide.

## Interface
Parameters:
- MULDIV_CYCLES, 4, EX occupancy of a mul/div instruction in cycles (legal range 2..15)
- NOP_WORD, 16'h0000, instruction word inserted on squash

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- instr_in  in  16  instruction from fetch
- pc_in  in  16  PC+2 of instr_in
- branch_taken  in  1  branch resolved taken in EX this cycle
- idex_memread  in  1  MemRead_out of ID/EX buffer
- idex_rd  in  4  destination register field held in ID/EX
- instr_out  out  16  registered instruction to decode
- pc_out  out  16  registered PC+2
- valid_out  out  1  instr_out is a real instruction (0 after reset/squash)
- rs_addr  out  4  instr_out[11:8], to RF read port 1 and IFID_RS forwarding path
- rt_addr  out  4  instr_out[7:4], to RF read port 2 and IFID_RT forwarding path
- funct_out  out  4  instr_out[3:0]
- pc_write  out  1  PC may advance this cycle
- idex_flush  out  1  drives IDEX_FLUSH of the ID/EX buffer
- stall  out  1  IF/ID is holding this cycle

## Operation
- Instruction format: [15:12] opcode, [11:8] rs, [7:4] rt, [3:0] funct.
- Mul/div: opcode 4'h0 with funct 4'h4 (mul) or 4'h5 (div).
- States: RUN, MD_STALL. A 4-bit down-counter md_cnt is used only in MD_STALL.
- load_use = valid_out & idex_memread & (idex_rd == rs_addr | idex_rd == rt_addr).
- is_md = valid_out & opcode==0 & funct in {4,5}.

Priority per cycle, highest first:
1. **branch_taken:** load NOP_WORD, valid_out<=0, pc_out<=pc_in. pc_write=1, idex_flush=1, stall=0. Go to RUN, md_cnt<=0. This applies in any state.
2. **MD_STALL:** hold instr/pc/valid. pc_write=0, idex_flush=1, stall=1. md_cnt decrements; at md_cnt==1 go to RUN (md_cnt<=0).
3. **RUN with load_use:** hold, pc_write=0, idex_flush=1, stall=1.
4. **RUN with is_md:** the mul/div passes into ID/EX (idex_flush=0). IF/ID loads instr_in, valid_out<=1, pc_write=1. Go to MD_STALL with md_cnt<=MULDIV_CYCLES-1.
5. **RUN otherwise:** load instr_in/pc_in, valid_out<=1, pc_write=1, idex_flush=0, stall=0.

Other rules:
- Load-use and mul/div are mutually exclusive by priority. A held load-use instruction that is itself a mul/div triggers MD_STALL on the cycle load_use clears.
- Register 0 gets no special treatment in the hazard compare.
- Invalid slots (valid_out=0) never raise load_use or is_md.

## Timing
- Reset (rst=0, asynchronous): instr_out=NOP_WORD, pc_out=0, valid_out=0, state=RUN, md_cnt=0. The derived outputs are then rs_addr=0, rt_addr=0, funct_out=0, pc_write=1, idex_flush=0, stall=0.
- Registered: instr_out, pc_out, valid_out, state, md_cnt.
- Combinational from current state and inputs: pc_write, idex_flush, stall, rs_addr, rt_addr, funct_out.
- Latency: instr_in appears on instr_out one cycle after capture.
- Load-use costs exactly 1 bubble. Flushing ID/EX clears idex_memread the next cycle, so load_use self-clears.
- Mul/div costs exactly MULDIV_CYCLES-1 bubbles after the mul/div enters ID/EX.
- Reset asserted mid-MD_STALL: immediate return to RUN, counter cleared, no residual stall after release.
- branch_taken coincident with load_use or MD_STALL: the squash wins and the stall is abandoned the same cycle.

## Test plan
- Reset release, then instr_in = 16'h1230, 16'h1450, ... with pc_in = 2, 4, ...: instr_out/pc_out follow one cycle later, valid_out=1, pc_write=1, idex_flush=0 throughout.
- Load-use: idex_memread=1, idex_rd=4'h3, instr_out=16'h2310. Expect stall=1, pc_write=0, idex_flush=1 for one cycle. With idex_memread dropped next cycle, the same instruction advances.
- Mul stall with MULDIV_CYCLES=4: instr_out=16'h0124 valid. That cycle idex_flush=0. Next 3 cycles stall=1, idex_flush=1, instr_out frozen on the following word. The 4th cycle resumes RUN.
- Branch during MD_STALL (second bubble): branch_taken=1. Next cycle instr_out=16'h0000, valid_out=0, state RUN, pc_write=1 that cycle, no further bubbles.
- Simultaneous branch_taken and load_use: squash occurs, pc_write=1, idex_flush=1, no hold.
- rst pulled low mid-MD_STALL (md_cnt=2): outputs go to reset values without a clock edge. After release, normal fetch resumes with no extra stall cycles.
